// File: rtl/pipe_trace_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : trace_pkg
//  Description : Shared types and constants for the retirement trace buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
package trace_pkg;

    typedef enum logic [1:0] {
        TS_IDLE  = 2'b00,
        TS_ARMED = 2'b01,
        TS_POST  = 2'b10,
        TS_DONE  = 2'b11
    } trace_state_t;

    localparam logic [1:0] TRIG_IMM = 2'b00;
    localparam logic [1:0] TRIG_PC  = 2'b01;
    localparam logic [1:0] TRIG_CYC = 2'b10;
    localparam logic [1:0] TRIG_EXT = 2'b11;

    // Packed entry layout is {pc, inst, d, rn, wreg, cycle}.
    function automatic int entry_width(input int pc_w, input int inst_w,
                                       input int data_w, input int rn_w,
                                       input int cyc_w);
        return pc_w + inst_w + data_w + rn_w + 1 + cyc_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_trace_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_trace_buffer_if
//  Description : Retire bus, capture control and readback port of the tracer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipe_trace_buffer_if
    import trace_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int PC_W   = 32,
    parameter int INST_W = 48,
    parameter int DATA_W = 32,
    parameter int RN_W   = 5,
    parameter int CYC_W  = 32
);
    localparam int AW = $clog2(DEPTH);

    logic              w_valid;
    logic [PC_W-1:0]   w_pc;
    logic [INST_W-1:0] w_inst;
    logic [DATA_W-1:0] w_d;
    logic [RN_W-1:0]   w_rn;
    logic              w_wreg;

    logic              arm;
    logic              abort;
    logic [1:0]        trig_mode;
    logic [CYC_W-1:0]  trig_value;
    logic              ext_trig;

    logic              rd_req;
    logic [AW-1:0]     rd_addr;
    logic              rd_valid;
    logic              rd_oob;
    logic [PC_W-1:0]   rd_pc;
    logic [INST_W-1:0] rd_inst;
    logic [DATA_W-1:0] rd_d;
    logic [RN_W-1:0]   rd_rn;
    logic              rd_wreg;
    logic [CYC_W-1:0]  rd_cycle;

    trace_state_t      state;
    logic [AW:0]       count;
    logic [AW-1:0]     trig_index;

    modport master (
        output w_valid, w_pc, w_inst, w_d, w_rn, w_wreg,
        output arm, abort, trig_mode, trig_value, ext_trig,
        output rd_req, rd_addr,
        input  rd_valid, rd_oob, rd_pc, rd_inst, rd_d, rd_rn, rd_wreg, rd_cycle,
        input  state, count, trig_index
    );

    modport slave (
        input  w_valid, w_pc, w_inst, w_d, w_rn, w_wreg,
        input  arm, abort, trig_mode, trig_value, ext_trig,
        input  rd_req, rd_addr,
        output rd_valid, rd_oob, rd_pc, rd_inst, rd_d, rd_rn, rd_wreg, rd_cycle,
        output state, count, trig_index
    );

endinterface
`default_nettype wire

// File: rtl/pipe_trace_buffer_ram.sv
`default_nettype none
// ============================================================================
//  Module      : trace_ram
//  Description : Simple dual-port RAM, one write port, registered read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module trace_ram #(
    parameter  int DEPTH = 64,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  wire logic             clock,
    input  wire logic             i_we,
    input  wire logic [AW-1:0]    i_waddr,
    input  wire logic [WIDTH-1:0] i_wdata,
    input  wire logic [AW-1:0]    i_raddr,
    output logic      [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Read-before-write: a colliding read returns the previous contents.
    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata <= r_mem[i_raddr];
    end

endmodule
`default_nettype wire

// File: rtl/pipe_trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_trace_buffer
//  Description : Triggered circular capture of W-stage retirements with readback.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_trace_buffer
    import trace_pkg::*;
#(
    parameter int DEPTH     = 64,
    parameter int POST_TRIG = 32,
    parameter int PC_W      = 32,
    parameter int INST_W    = 48,
    parameter int DATA_W    = 32,
    parameter int RN_W      = 5,
    parameter int CYC_W     = 32
) (
    input  wire logic          clock,
    input  wire logic          resetn,
    pipe_trace_buffer_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = entry_width(PC_W, INST_W, DATA_W, RN_W, CYC_W);
    localparam logic [AW:0] C_DEPTH     = (AW+1)'(DEPTH);
    localparam logic [AW:0] C_POST_TRIG = (AW+1)'(POST_TRIG);

    trace_state_t     r_state, w_state_nxt;
    logic [AW-1:0]    r_wr_ptr, w_wr_ptr_nxt;
    logic [AW:0]      r_count, w_count_nxt;
    logic [AW:0]      r_post_cnt, w_post_cnt_nxt;
    logic             r_ext_sticky, w_ext_sticky_nxt;
    logic [CYC_W-1:0] r_cycle;
    logic             r_rd_valid;
    logic             r_rd_oob;

    logic             w_we;
    logic             w_trig_cond;
    logic [EW-1:0]    w_wdata;
    logic [EW-1:0]    w_rdata;
    logic [AW-1:0]    w_rd_phys;
    logic             w_rd_oob;
    logic             w_rd_show;

    logic [PC_W-1:0]   w_e_pc;
    logic [INST_W-1:0] w_e_inst;
    logic [DATA_W-1:0] w_e_d;
    logic [RN_W-1:0]   w_e_rn;
    logic              w_e_wreg;
    logic [CYC_W-1:0]  w_e_cycle;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_cycle <= '0;
        end else begin
            r_cycle <= r_cycle + CYC_W'(1);
        end
    end

    // The sticky flag covers external pulses that land between retirements.
    always_comb begin
        w_trig_cond = 1'b0;
        unique case (bus.trig_mode)
            TRIG_IMM: w_trig_cond = 1'b1;
            TRIG_PC:  w_trig_cond = (bus.w_pc == bus.trig_value[PC_W-1:0]);
            TRIG_CYC: w_trig_cond = (r_cycle >= bus.trig_value);
            TRIG_EXT: w_trig_cond = bus.ext_trig || r_ext_sticky;
            default:  w_trig_cond = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state      <= TS_IDLE;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_post_cnt   <= '0;
            r_ext_sticky <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_count      <= w_count_nxt;
            r_post_cnt   <= w_post_cnt_nxt;
            r_ext_sticky <= w_ext_sticky_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_wr_ptr_nxt     = r_wr_ptr;
        w_count_nxt      = r_count;
        w_post_cnt_nxt   = r_post_cnt;
        w_ext_sticky_nxt = r_ext_sticky;
        w_we             = 1'b0;

        if (bus.abort) begin
            w_state_nxt = TS_IDLE;
        end else begin
            unique case (r_state)
                TS_IDLE, TS_DONE: begin
                    if (bus.arm) begin
                        w_state_nxt      = TS_ARMED;
                        w_wr_ptr_nxt     = '0;
                        w_count_nxt      = '0;
                        w_post_cnt_nxt   = '0;
                        w_ext_sticky_nxt = 1'b0;
                    end
                end
                TS_ARMED: begin
                    if (bus.ext_trig) begin
                        w_ext_sticky_nxt = 1'b1;
                    end
                    if (bus.w_valid) begin
                        w_we = 1'b1;
                        if (w_trig_cond) begin
                            w_post_cnt_nxt = (AW+1)'(1);
                            w_state_nxt    = (POST_TRIG == 1) ? TS_DONE : TS_POST;
                        end
                    end
                end
                TS_POST: begin
                    if (bus.w_valid) begin
                        w_we           = 1'b1;
                        w_post_cnt_nxt = r_post_cnt + (AW+1)'(1);
                        if (w_post_cnt_nxt == C_POST_TRIG) begin
                            w_state_nxt = TS_DONE;
                        end
                    end
                end
                default: w_state_nxt = TS_IDLE;
            endcase

            if (w_we) begin
                w_wr_ptr_nxt = r_wr_ptr + AW'(1);
                if (r_count != C_DEPTH) begin
                    w_count_nxt = r_count + (AW+1)'(1);
                end
            end
        end
    end

    assign w_wdata = {bus.w_pc, bus.w_inst, bus.w_d, bus.w_rn, bus.w_wreg, r_cycle};

    // Logical index 0 is the oldest entry, count places behind the write pointer.
    assign w_rd_phys = r_wr_ptr - r_count[AW-1:0] + bus.rd_addr;
    assign w_rd_oob  = ({1'b0, bus.rd_addr} >= r_count);

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_ram (
        .clock   (clock),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wdata),
        .i_raddr (w_rd_phys),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_rd_valid <= 1'b0;
            r_rd_oob   <= 1'b0;
        end else begin
            r_rd_valid <= bus.rd_req;
            r_rd_oob   <= bus.rd_req && w_rd_oob;
        end
    end

    // RAM output is not reset, so data is masked unless a valid in-range read.
    assign w_rd_show = r_rd_valid && !r_rd_oob;
    assign {w_e_pc, w_e_inst, w_e_d, w_e_rn, w_e_wreg, w_e_cycle} = w_rdata;

    assign bus.rd_valid = r_rd_valid;
    assign bus.rd_oob   = r_rd_oob;
    assign bus.rd_pc    = w_rd_show ? w_e_pc    : '0;
    assign bus.rd_inst  = w_rd_show ? w_e_inst  : '0;
    assign bus.rd_d     = w_rd_show ? w_e_d     : '0;
    assign bus.rd_rn    = w_rd_show ? w_e_rn    : '0;
    assign bus.rd_wreg  = w_rd_show ? w_e_wreg  : 1'b0;
    assign bus.rd_cycle = w_rd_show ? w_e_cycle : '0;

    assign bus.state      = r_state;
    assign bus.count      = r_count;
    assign bus.trig_index = (r_state == TS_DONE) ? AW'(r_count - C_POST_TRIG) : '0;

endmodule
`default_nettype wire
